// File: rtl/qdiv_pkg.sv
// qdiv_pkg: shared types and helpers for the parametrised signed-magnitude
// Q-format divider (qdiv_param) and its result packer (qdiv_sm_pack).
//
// Contents:
//   state_t          - divider control states (IDLE, CALC, DONE)
//   cnt_width()      - width of the iteration counter, clog2(N+Q+1)
//   sm_magnitude()   - strip the sign bit from an n-bit signed-magnitude word
//   sm_sign()        - extract the sign bit of an n-bit signed-magnitude word
//   sm_pack()        - join sign and magnitude, never producing negative zero
//
// The sign-magnitude helpers work on 64-bit containers so that one function
// serves every width; callers size-cast the result back to their own width.
// This limits N to 64 bits.
package qdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must hold values 0..ITER, and ITER never exceeds N+Q.
  function automatic int cnt_width(input int n, input int q);
    return $clog2(n + q + 1);
  endfunction

  function automatic logic [63:0] sm_magnitude(input logic [63:0] w, input int n);
    return w & ((64'd1 << (n - 1)) - 64'd1);
  endfunction

  function automatic logic sm_sign(input logic [63:0] w, input int n);
    return 1'((w >> (n - 1)) & 64'd1);
  endfunction

  // A zero magnitude always gets a positive sign.
  function automatic logic [63:0] sm_pack(input logic sign, input logic [63:0] mag,
                                          input int n);
    logic keep_sign;
    keep_sign = sign & (mag != 64'd0);
    return mag | (64'(keep_sign) << (n - 1));
  endfunction

endpackage

// File: rtl/qdiv_if.sv
// qdiv_if: request/result bundle of the qdiv_param divider.
//
// Signals:
//   i_start        - start request, honoured only while o_busy is low
//   i_dividend     - N-bit signed-magnitude Q-format dividend
//   i_divisor      - N-bit signed-magnitude Q-format divisor
//   o_quotient_out - N-bit signed-magnitude Q-format quotient
//   o_complete     - result valid (level)
//   o_overflow     - quotient was saturated
//   o_div_by_zero  - divisor magnitude was zero
//   o_busy         - iteration in progress
//
// Modports: master drives requests (the requester), slave is the divider.
interface qdiv_if #(
  parameter int N = 32
);
  import qdiv_pkg::*;

  logic         i_start;
  logic [N-1:0] i_dividend;
  logic [N-1:0] i_divisor;
  logic [N-1:0] o_quotient_out;
  logic         o_complete;
  logic         o_overflow;
  logic         o_div_by_zero;
  logic         o_busy;

  modport master (
    output i_start, i_dividend, i_divisor,
    input  o_quotient_out, o_complete, o_overflow, o_div_by_zero, o_busy
  );

  modport slave (
    input  i_start, i_dividend, i_divisor,
    output o_quotient_out, o_complete, o_overflow, o_div_by_zero, o_busy
  );

endinterface

// File: rtl/qdiv_sm_pack.sv
// qdiv_sm_pack: combinational result formation for qdiv_param.
// Takes the raw restoring-division quotient, optionally rounds it half-up,
// saturates it to N-1 magnitude bits and packs it with the result sign.
//
// Ports:
//   raw_quotient - N-1+Q+ROUND quotient bits, MSB first order as produced
//   sign         - result sign (dividend sign XOR divisor sign)
//   packed_word  - N-bit signed-magnitude result (never negative zero)
//   overflow     - magnitude did not fit and was saturated to all ones
module qdiv_sm_pack
  import qdiv_pkg::*;
#(
  parameter int N     = 32,
  parameter int Q     = 15,
  parameter int ROUND = 0
) (
  input  logic [N+Q+ROUND-2:0] raw_quotient,
  input  logic                 sign,
  output logic [N-1:0]         packed_word,
  output logic                 overflow
);

  localparam int QW = N - 1 + Q;

  // One spare top bit so a rounding carry is never lost.
  logic [QW:0]  rounded;
  logic [N-2:0] magnitude;

  // With rounding the raw quotient carries one extra (half) bit below the
  // result LSB; adding it and dropping it gives round-half-up.
  generate
    if (ROUND != 0) begin : g_round
      assign rounded = {1'b0, raw_quotient[QW:1]} + (QW + 1)'(raw_quotient[0]);
    end else begin : g_trunc
      assign rounded = {1'b0, raw_quotient};
    end
  endgenerate

  // Anything at or above bit N-1 cannot be represented in the magnitude field.
  always_comb begin
    overflow    = |rounded[QW:N-1];
    magnitude   = overflow ? {(N-1){1'b1}} : rounded[N-2:0];
    packed_word = N'(sm_pack(sign, 64'(magnitude), N));
  end

endmodule

// File: rtl/qdiv_param.sv
// qdiv_param: parametrised sequential divider for signed-magnitude Q-format
// words. Divides (|dividend| << Q) by |divisor| with a restoring algorithm,
// one quotient bit per clock, then rounds/saturates/packs the result.
//
// Parameters:
//   N     - word width including sign bit (N >= 4, N <= 64)
//   Q     - fractional bits (1 <= Q <= N-2)
//   ROUND - 0 truncates, 1 rounds half-up (costs one extra iteration)
//
// Ports:
//   i_clk - clock, rising edge
//   i_rst - synchronous active-high reset
//   bus   - qdiv_if slave: start/operands in, quotient and status out
//
// Timing: the result is valid ITER+1 edges after the accept edge, where
// ITER = N-1+Q+ROUND. A zero divisor completes one edge after accept.
module qdiv_param
  import qdiv_pkg::*;
#(
  parameter int N     = 32,
  parameter int Q     = 15,
  parameter int ROUND = 0
) (
  input  logic   i_clk,
  input  logic   i_rst,
  qdiv_if.slave  bus
);

  localparam int ITER  = N - 1 + Q + ROUND;
  localparam int SHIFT = Q + ROUND;
  localparam int CW    = cnt_width(N, Q);

  state_t        state_q;
  state_t        state_d;

  logic [CW-1:0]   cnt_q;
  logic [N-2:0]    rem_q;
  logic [N-2:0]    divisor_q;
  logic [ITER-1:0] num_q;
  logic [ITER-1:0] quo_q;
  logic            sign_q;
  logic            dend_sign_q;
  logic            dz_q;

  logic [N-1:0]    quotient_q;
  logic            complete_q;
  logic            overflow_q;
  logic            div_by_zero_q;

  logic            accept;
  logic            last_step;
  logic [N-2:0]    dividend_mag;
  logic [N-2:0]    divisor_mag;
  logic            dividend_sign;
  logic            divisor_sign;

  logic [N-1:0]    trial;
  logic [N-1:0]    trial_sub;
  logic            trial_ge;
  logic [N-2:0]    rem_next;

  logic [N-1:0]    pack_word;
  logic            pack_overflow;

  assign dividend_mag  = (N-1)'(sm_magnitude(64'(bus.i_dividend), N));
  assign divisor_mag   = (N-1)'(sm_magnitude(64'(bus.i_divisor), N));
  assign dividend_sign = sm_sign(64'(bus.i_dividend), N);
  assign divisor_sign  = sm_sign(64'(bus.i_divisor), N);

  // A request is only honoured when no division is in flight.
  assign accept    = bus.i_start && (state_q != CALC);
  assign last_step = (cnt_q == CW'(ITER));

  // Restoring step. The shifted partial remainder needs N bits; because the
  // stored remainder is always below the divisor, the subtraction borrows
  // (top bit set) exactly when the trial value is smaller than the divisor.
  assign trial     = {rem_q, num_q[ITER-1]};
  assign trial_sub = trial - {1'b0, divisor_q};
  assign trial_ge  = ~trial_sub[N-1];
  assign rem_next  = trial_ge ? trial_sub[N-2:0] : trial[N-2:0];

  qdiv_sm_pack #(
    .N     (N),
    .Q     (Q),
    .ROUND (ROUND)
  ) u_pack (
    .raw_quotient (quo_q),
    .sign         (sign_q),
    .packed_word  (pack_word),
    .overflow     (pack_overflow)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. A zero divisor spends a single cycle in CALC and leaves;
  // otherwise CALC runs ITER iterations plus one result-formation edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.i_start) begin
          state_d = CALC;
        end
      end
      CALC: begin
        if (dz_q || last_step) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture, iteration and result registers. Reset discards any
  // in-flight division; the held result survives until the next accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q         <= '0;
      rem_q         <= '0;
      divisor_q     <= '0;
      num_q         <= '0;
      quo_q         <= '0;
      sign_q        <= 1'b0;
      dend_sign_q   <= 1'b0;
      dz_q          <= 1'b0;
      quotient_q    <= '0;
      complete_q    <= 1'b0;
      overflow_q    <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else if (accept) begin
      cnt_q         <= '0;
      rem_q         <= '0;
      divisor_q     <= divisor_mag;
      num_q         <= {dividend_mag, {SHIFT{1'b0}}};
      quo_q         <= '0;
      sign_q        <= dividend_sign ^ divisor_sign;
      dend_sign_q   <= dividend_sign;
      dz_q          <= (divisor_mag == '0);
      complete_q    <= 1'b0;
      overflow_q    <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else if (state_q == CALC) begin
      if (dz_q) begin
        quotient_q    <= {dend_sign_q, {(N-1){1'b1}}};
        complete_q    <= 1'b1;
        overflow_q    <= 1'b1;
        div_by_zero_q <= 1'b1;
      end else if (last_step) begin
        quotient_q    <= pack_word;
        complete_q    <= 1'b1;
        overflow_q    <= pack_overflow;
      end else begin
        rem_q <= rem_next;
        quo_q <= {quo_q[ITER-2:0], trial_ge};
        num_q <= {num_q[ITER-2:0], 1'b0};
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign bus.o_quotient_out = quotient_q;
  assign bus.o_complete     = complete_q;
  assign bus.o_overflow     = overflow_q;
  assign bus.o_div_by_zero  = div_by_zero_q;
  assign bus.o_busy         = (state_q == CALC);

endmodule

// File: tb/tb_qdiv_param.sv
// tb_qdiv_param: self-checking bench for qdiv_param. Two instances with
// N=32, Q=15 (ROUND=0 and ROUND=1) receive identical requests; results are
// compared against an arithmetic reference model of the divider.
module tb_qdiv_param;

  localparam int N = 32;
  localparam int Q = 15;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  qdiv_if #(.N(N)) if0 ();
  qdiv_if #(.N(N)) if1 ();

  qdiv_param #(.N(N), .Q(Q), .ROUND(0)) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (if0)
  );

  qdiv_param #(.N(N), .Q(Q), .ROUND(1)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (if1)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0] q;
    logic         ovf;
    logic         dz;
    logic         busy_acc;
    logic         comp_acc;
    logic         busy_done;
    int           lat;
  } obs_t;

  // Reference: plain integer division of the magnitudes, then round,
  // saturate and attach the sign.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                input int r, output logic [N-1:0] q,
                                output logic ovf, output logic dz, output int lat);
    logic [63:0] ma, mb, quo, maxmag;
    logic        s;
    ma     = 64'(a[N-2:0]);
    mb     = 64'(b[N-2:0]);
    maxmag = (64'd1 << (N - 1)) - 64'd1;
    if (mb == 64'd0) begin
      q   = {a[N-1], {(N-1){1'b1}}};
      ovf = 1'b1;
      dz  = 1'b1;
      lat = 1;
      return;
    end
    quo = (ma << (Q + r)) / mb;
    if (r != 0) quo = (quo >> 1) + (quo & 64'd1);
    dz  = 1'b0;
    lat = N - 1 + Q + r + 1;
    ovf = (quo > maxmag);
    if (ovf) quo = maxmag;
    s = (quo != 64'd0) && (a[N-1] ^ b[N-1]);
    q = {s, quo[N-2:0]};
  endfunction

  // Issue one request to both DUTs, scramble the operands after the accept
  // edge, and collect what each DUT reports.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               output obs_t o0, output obs_t o1);
    @(negedge clk);
    if0.i_start = 1'b1; if0.i_dividend = a; if0.i_divisor = b;
    if1.i_start = 1'b1; if1.i_dividend = a; if1.i_divisor = b;
    @(posedge clk);
    #1;
    if0.i_start = 1'b0; if0.i_dividend = $urandom; if0.i_divisor = $urandom;
    if1.i_start = 1'b0; if1.i_dividend = $urandom; if1.i_divisor = $urandom;
    o0 = '{q: '0, ovf: 1'b0, dz: 1'b0, busy_acc: if0.o_busy, comp_acc: if0.o_complete,
           busy_done: 1'b0, lat: -1};
    o1 = '{q: '0, ovf: 1'b0, dz: 1'b0, busy_acc: if1.o_busy, comp_acc: if1.o_complete,
           busy_done: 1'b0, lat: -1};
    for (int e = 1; e <= 64 && (o0.lat < 0 || o1.lat < 0); e++) begin
      @(posedge clk);
      #1;
      if (o0.lat < 0 && if0.o_complete === 1'b1) begin
        o0.lat = e; o0.q = if0.o_quotient_out;
        o0.ovf = if0.o_overflow; o0.dz = if0.o_div_by_zero;
      end
      if (o1.lat < 0 && if1.o_complete === 1'b1) begin
        o1.lat = e; o1.q = if1.o_quotient_out;
        o1.ovf = if1.o_overflow; o1.dz = if1.o_div_by_zero;
      end
    end
    o0.busy_done = if0.o_busy;
    o1.busy_done = if1.o_busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if0.i_start = 1'b0; if0.i_dividend = '0; if0.i_divisor = '0;
    if1.i_start = 1'b0; if1.i_dividend = '0; if1.i_divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({if0.o_quotient_out, if0.o_complete, if0.o_overflow, if0.o_div_by_zero, if0.o_busy} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_dut0: got q=%h c=%b o=%b z=%b b=%b expected all zero",
               if0.o_quotient_out, if0.o_complete, if0.o_overflow, if0.o_div_by_zero, if0.o_busy);
    end
    checks++;
    if ({if1.o_quotient_out, if1.o_complete, if1.o_overflow, if1.o_div_by_zero, if1.o_busy} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_dut1: got q=%h c=%b o=%b z=%b b=%b expected all zero",
               if1.o_quotient_out, if1.o_complete, if1.o_overflow, if1.o_div_by_zero, if1.o_busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Hand-derived vectors; expected words are constants, latency follows
  // from ITER+1 (47 for ROUND=0, 48 for ROUND=1) or 1 for a zero divisor.
  task automatic test_directed();
    logic [N-1:0] ta [6] = '{32'h00018000, 32'h80018000, 32'h00000000,
                             32'h40000000, 32'h80008000, 32'h00008000};
    logic [N-1:0] tb [6] = '{32'h00010000, 32'h00010000, 32'h80008000,
                             32'h00000001, 32'h80000000, 32'h00018000};
    logic [N-1:0] tq0 [6] = '{32'h0000C000, 32'h8000C000, 32'h00000000,
                              32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00002AAA};
    logic [N-1:0] tq1 [6] = '{32'h0000C000, 32'h8000C000, 32'h00000000,
                              32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00002AAB};
    logic [1:0]   tf [6]  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00};
    obs_t o0, o1, o;
    logic [N-1:0] eq;
    int elat;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(ta[i], tb[i], o0, o1);
      for (int d = 0; d < 2; d++) begin
        o    = (d == 0) ? o0 : o1;
        eq   = (d == 0) ? tq0[i] : tq1[i];
        elat = tf[i][0] ? 1 : 47 + d;
        checks++;
        if (o.q !== eq) begin
          failures++;
          $display("[TB] FAIL directed%0d_quotient_dut%0d: got %h expected %h", i, d, o.q, eq);
        end
        checks++;
        if ({o.ovf, o.dz} !== tf[i]) begin
          failures++;
          $display("[TB] FAIL directed%0d_flags_dut%0d: got ovf/dz=%b%b expected %b",
                   i, d, o.ovf, o.dz, tf[i]);
        end
        checks++;
        if (o.lat !== elat) begin
          failures++;
          $display("[TB] FAIL directed%0d_latency_dut%0d: got %0d expected %0d", i, d, o.lat, elat);
        end
        checks++;
        if ({o.comp_acc, o.busy_done} !== 2'b00) begin
          failures++;
          $display("[TB] FAIL directed%0d_status_dut%0d: got complete@accept=%b busy@done=%b expected 0 0",
                   i, d, o.comp_acc, o.busy_done);
        end
      end
    end
  endtask

  // Random operands of varied magnitude, occasional zero divisor; each
  // request starts the cycle after the previous one completed.
  task automatic test_random();
    obs_t o0, o1, o;
    logic [N-1:0] a, b, eq;
    logic eovf, edz;
    int elat;
    for (int i = 0; i < 20; i++) begin
      a = {1'($urandom), 31'($urandom >> $urandom_range(0, 31))};
      b = {1'($urandom), 31'($urandom >> $urandom_range(0, 31))};
      if ($urandom_range(0, 7) == 0) b[N-2:0] = '0;
      applyStimulus(a, b, o0, o1);
      for (int d = 0; d < 2; d++) begin
        o = (d == 0) ? o0 : o1;
        model(a, b, d, eq, eovf, edz, elat);
        checks++;
        if (o.q !== eq || {o.ovf, o.dz} !== {eovf, edz}) begin
          failures++;
          $display("[TB] FAIL random%0d_result_dut%0d: %h/%h got %h ovf=%b dz=%b expected %h ovf=%b dz=%b",
                   i, d, a, b, o.q, o.ovf, o.dz, eq, eovf, edz);
        end
        checks++;
        if (o.lat !== elat) begin
          failures++;
          $display("[TB] FAIL random%0d_latency_dut%0d: got %0d expected %0d", i, d, o.lat, elat);
        end
        checks++;
        if (o.comp_acc !== 1'b0 || o.busy_done !== 1'b0 || (!edz && o.busy_acc !== 1'b1)) begin
          failures++;
          $display("[TB] FAIL random%0d_status_dut%0d: got complete@accept=%b busy@accept=%b busy@done=%b",
                   i, d, o.comp_acc, o.busy_acc, o.busy_done);
        end
      end
    end
  endtask

  // After completion with no new request, the result must not move.
  task automatic test_done_hold();
    obs_t o0, o1;
    logic [N-1:0] a, b, eq0, eq1;
    logic eovf, edz;
    int elat;
    a = 32'h80050000;
    b = 32'h00030000;
    applyStimulus(a, b, o0, o1);
    model(a, b, 0, eq0, eovf, edz, elat);
    model(a, b, 1, eq1, eovf, edz, elat);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({if0.o_quotient_out, if0.o_complete, if0.o_busy} !== {eq0, 2'b10}) begin
      failures++;
      $display("[TB] FAIL hold_dut0: got q=%h c=%b b=%b expected q=%h c=1 b=0",
               if0.o_quotient_out, if0.o_complete, if0.o_busy, eq0);
    end
    checks++;
    if ({if1.o_quotient_out, if1.o_complete, if1.o_busy} !== {eq1, 2'b10}) begin
      failures++;
      $display("[TB] FAIL hold_dut1: got q=%h c=%b b=%b expected q=%h c=1 b=0",
               if1.o_quotient_out, if1.o_complete, if1.o_busy, eq1);
    end
  endtask

  // A start pulse with other operands mid-iteration must be ignored.
  task automatic test_ignore_start();
    logic [N-1:0] a, b, eq, q_seen [2];
    logic eovf, edz;
    int elat, lat [2];
    a = 32'h00050000;
    b = 32'h80030000;
    @(negedge clk);
    if0.i_start = 1'b1; if0.i_dividend = a; if0.i_divisor = b;
    if1.i_start = 1'b1; if1.i_dividend = a; if1.i_divisor = b;
    @(posedge clk);
    #1;
    if0.i_start = 1'b0; if1.i_start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    if0.i_start = 1'b1; if0.i_dividend = 32'h00008000; if0.i_divisor = 32'h00000000;
    if1.i_start = 1'b1; if1.i_dividend = 32'h00008000; if1.i_divisor = 32'h00000000;
    @(posedge clk);
    #1;
    if0.i_start = 1'b0; if1.i_start = 1'b0;
    lat = '{-1, -1};
    q_seen = '{'0, '0};
    for (int e = 11; e <= 80 && (lat[0] < 0 || lat[1] < 0); e++) begin
      @(posedge clk);
      #1;
      if (lat[0] < 0 && if0.o_complete === 1'b1) begin lat[0] = e; q_seen[0] = if0.o_quotient_out; end
      if (lat[1] < 0 && if1.o_complete === 1'b1) begin lat[1] = e; q_seen[1] = if1.o_quotient_out; end
    end
    for (int d = 0; d < 2; d++) begin
      model(a, b, d, eq, eovf, edz, elat);
      checks++;
      if (q_seen[d] !== eq || lat[d] !== elat) begin
        failures++;
        $display("[TB] FAIL ignore_start_dut%0d: got q=%h lat=%0d expected q=%h lat=%0d",
                 d, q_seen[d], lat[d], eq, elat);
      end
    end
  endtask

  // Reset in the middle of an iteration clears everything at once; the
  // following request must then complete normally.
  task automatic test_reset_midflight();
    obs_t o0, o1, o;
    logic [N-1:0] a, b, eq;
    logic eovf, edz;
    int elat;
    @(negedge clk);
    if0.i_start = 1'b1; if0.i_dividend = 32'h00018000; if0.i_divisor = 32'h00010000;
    if1.i_start = 1'b1; if1.i_dividend = 32'h00018000; if1.i_divisor = 32'h00010000;
    @(posedge clk);
    #1;
    if0.i_start = 1'b0; if1.i_start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({if0.o_quotient_out, if0.o_complete, if0.o_overflow, if0.o_div_by_zero, if0.o_busy} !== '0 ||
        {if1.o_quotient_out, if1.o_complete, if1.o_overflow, if1.o_div_by_zero, if1.o_busy} !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_clear: got dut0 q=%h c=%b b=%b dut1 q=%h c=%b b=%b expected all zero",
               if0.o_quotient_out, if0.o_complete, if0.o_busy,
               if1.o_quotient_out, if1.o_complete, if1.o_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    a = 32'h00008000;
    b = 32'h80018000;
    applyStimulus(a, b, o0, o1);
    for (int d = 0; d < 2; d++) begin
      o = (d == 0) ? o0 : o1;
      model(a, b, d, eq, eovf, edz, elat);
      checks++;
      if (o.q !== eq || o.lat !== elat || o.ovf !== eovf) begin
        failures++;
        $display("[TB] FAIL midreset_after_dut%0d: got q=%h lat=%0d ovf=%b expected q=%h lat=%0d ovf=%b",
                 d, o.q, o.lat, o.ovf, eq, elat, eovf);
      end
    end
  endtask

  initial begin
    $display("[TB] qdiv_param bench start");
    test_reset();
    test_directed();
    test_random();
    test_done_hold();
    test_ignore_start();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected bench completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
